// File: rtl/bfp_vector_encoder.sv
// Block-floating-point vector encoder: buffers V floats, finds the shared max exponent, streams aligned mantissas P lanes per beat.
// Latency: V-th accept at cycle t -> beats at t+1..t+V/P, out_done pulse at t+V/P+1, next accept at t+V/P+2 at the earliest.
// Backpressure: in_ready is low while streaming and during the done pulse; the output stream has no backpressure.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   in_valid/ready  input handshake, one float {sign, exp, frac} per accepted cycle on in_float
//   out_mants       P signed (BFPM+2)-bit aligned mantissas, lane k = element b*P+k of beat b
//   out_vals_rdy    out_mants valid this cycle
//   out_done        one-cycle pulse after the last beat of a vector
//   out_exp         shared biased exponent, held until the next vector starts streaming
// Build option: define BFP_ROUND_EN for round-to-nearest (ties away from zero) with saturation;
// otherwise the magnitude is truncated toward zero.

module bfp_vector_encoder #(
    parameter int V    = 16,
    parameter int P    = 4,
    parameter int BIT  = 32,
    parameter int FPM  = 23,
    parameter int BFPM = 7
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BIT-1:0]             in_float,
    output logic [P-1:0][BFPM+1:0]     out_mants,
    output logic                       out_vals_rdy,
    output logic                       out_done,
    output logic [BIT-FPM-2:0]         out_exp
);

    localparam int EW = BIT - FPM - 1;
    localparam int NB = V / P;
    localparam int LW = (V > 1) ? $clog2(V) : 1;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int MW = BFPM + 2;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [LW-1:0]          ld_cnt_q, ld_cnt_d;
    logic [BW-1:0]          beat_cnt_q, beat_cnt_d;
    logic [EW-1:0]          max_exp_q, max_exp_d;
    logic [EW-1:0]          out_exp_q, out_exp_d;
    logic [P-1:0][MW-1:0]   out_mants_q, out_mants_d;
    logic [BIT-1:0]         elem_q [V];
    logic [BIT-1:0]         elem_d [V];

    logic [EW-1:0]          in_exp;
    logic [EW-1:0]          new_max;
    logic [EW-1:0]          enc_exp;
    logic [BW-1:0]          nb_sel;
    logic [BIT-1:0]         src [P];
    logic [P-1:0][MW-1:0]   next_beat;

    // Encode one float against the shared exponent into a signed MW-bit mantissa.
    // A zero exponent field (zero/denormal) always encodes as 0.
    function automatic logic [MW-1:0] encode_elem(input logic [BIT-1:0] f,
                                                  input logic [EW-1:0]  shared);
        logic [EW-1:0] ex;
        logic [EW-1:0] d;
        logic [MW-1:0] mag;
`ifdef BFP_ROUND_EN
        logic [FPM+1:0] full;
        logic [FPM+1:0] half;
        logic [FPM+1:0] sum;
        int             sh;
`endif
        ex  = f[BIT-2:FPM];
        d   = shared - ex;
        mag = '0;
`ifdef BFP_ROUND_EN
        // One rounding step covers both the fraction truncation and the alignment
        // shift: shift the full significand by (d + dropped fraction bits) with a
        // half-LSB bias. Beyond d = BFPM+1 the value is below half an LSB.
        full = {1'b0, 1'b1, f[FPM-1:0]};
        half = '0;
        sum  = '0;
        sh   = int'(d) + (FPM - BFPM);
        if (ex != '0 && d <= EW'(BFPM + 1)) begin
            if (sh == 0) begin
                sum = full;
            end else begin
                half = {{(FPM+1){1'b0}}, 1'b1} << (sh - 1);
                sum  = (full + half) >> sh;
            end
            mag = sum[MW-1:0];
            // Rounding up from all-ones lands on 2^(BFPM+1); clamp to the max magnitude.
            if (mag[MW-1]) begin
                mag = {1'b0, {(MW-1){1'b1}}};
            end
        end
`else
        if (ex != '0) begin
            mag = {1'b0, 1'b1, f[FPM-1:FPM-BFPM]} >> d;
        end
`endif
        return f[BIT-1] ? -mag : mag;
    endfunction

    // Select which beat to encode next and against which exponent. On the final
    // accept the max is not registered yet, so beat 0 uses the in-flight max.
    always_comb begin
        in_exp  = in_float[BIT-2:FPM];
        new_max = (ld_cnt_q == '0 || in_exp > max_exp_q) ? in_exp : max_exp_q;
        nb_sel  = '0;
        enc_exp = out_exp_q;
        if (state_q == ST_STREAM) begin
            nb_sel = beat_cnt_q + BW'(1);
        end else begin
            enc_exp = new_max;
        end
    end

    always_comb begin
        for (int k = 0; k < P; k++) begin
            src[k] = '0;
        end
        for (int b = 0; b < NB; b++) begin
            if (nb_sel == BW'(b)) begin
                for (int k = 0; k < P; k++) begin
                    src[k] = elem_q[b*P+k];
                end
            end
        end
        // With a single beat per vector the last element is still on the input bus.
        if (NB == 1 && state_q != ST_STREAM) begin
            src[P-1] = in_float;
        end
        for (int k = 0; k < P; k++) begin
            next_beat[k] = encode_elem(src[k], enc_exp);
        end
    end

    always_comb begin
        state_d     = state_q;
        ld_cnt_d    = ld_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        max_exp_d   = max_exp_q;
        out_exp_d   = out_exp_q;
        out_mants_d = '0;
        elem_d      = elem_q;

        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    elem_d[ld_cnt_q] = in_float;
                    max_exp_d        = new_max;
                    if (ld_cnt_q == LW'(V - 1)) begin
                        state_d     = ST_STREAM;
                        ld_cnt_d    = '0;
                        beat_cnt_d  = '0;
                        out_exp_d   = new_max;
                        out_mants_d = next_beat;
                    end else begin
                        ld_cnt_d = ld_cnt_q + LW'(1);
                    end
                end
            end
            ST_STREAM: begin
                if (beat_cnt_q == BW'(NB - 1)) begin
                    state_d    = ST_DONE;
                    beat_cnt_d = '0;
                end else begin
                    beat_cnt_d  = beat_cnt_q + BW'(1);
                    out_mants_d = next_beat;
                end
            end
            ST_DONE: begin
                state_d  = ST_LOAD;
                ld_cnt_d = '0;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_LOAD;
            ld_cnt_q    <= '0;
            beat_cnt_q  <= '0;
            max_exp_q   <= '0;
            out_exp_q   <= '0;
            out_mants_q <= '0;
        end else begin
            state_q     <= state_d;
            ld_cnt_q    <= ld_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            max_exp_q   <= max_exp_d;
            out_exp_q   <= out_exp_d;
            out_mants_q <= out_mants_d;
        end
    end

    // Element storage needs no reset: a vector is only streamed after all V slots are rewritten.
    always_ff @(posedge clk) begin
        elem_q <= elem_d;
    end

    assign in_ready     = (state_q == ST_LOAD);
    assign out_vals_rdy = (state_q == ST_STREAM);
    assign out_done     = (state_q == ST_DONE);
    assign out_exp      = out_exp_q;
    assign out_mants    = out_mants_q;

endmodule
